matrix_exe_sequencer: RTL and testbench
=======================================

# matrix_exe_sequencer

Execution sequencer that sits directly upstream of the matrix ALU and drives it. It fetches 32-bit instructions from instruction memory and reads operand matrices from main memory. It writes the operands and the execute strobe to the matrix ALU, reads the result back, and stores it to main memory. It owns the shared address, nRead, nWrite and ExeDataOut bus, one access per cycle.

## Interface
Parameters:
- PC_W, 12, program counter width; instruction address is {4'h0, PC}.
- HALT_OP, 8'hFF, opcode that stops execution.

Ports:
- Clk  in  1  system clock; all state changes on posedge Clk.
- Reset  in  1  asynchronous, active-high reset.
- Go  in  1  start pulse, sampled only in IDLE.
- DataIn  in  256  read data from memory or the matrix ALU; captured at the posedge that ends a read cycle.
- address  out  16  bus address; [15:12]: 0=instr mem, 1=main mem, 2=matrix ALU.
- nRead  out  1  active-low read strobe.
- nWrite  out  1  active-low write strobe.
- ExeDataOut  out  256  write data.
- PC  out  PC_W  address of the current instruction.
- Busy  out  1  high in every state except IDLE and HALT.
- Halted  out  1  high in HALT.
- IllegalOp  out  1  sticky; set on an unknown opcode, cleared by Reset or by Go.

## Operation
- Instruction word is DataIn[31:0]:
  - op = [31:24]
  - dst = [23:16]
  - s1 = [15:8]
  - s2 = [7:0]
- Main-memory addresses: {8'h10, field}.
- Matrix ALU sub-addresses (address[11:0]): SRC1=12'h000, SRC2=12'h001, SI=12'h002, RES=12'h003.
- Legal opcodes are 8'h00–8'h07 and HALT_OP. Any other opcode: set IllegalOp, skip the instruction (no ALU access), PC+1.
- State sequence, one cycle per state:
  - IDLE: Go=1 -> FETCH, PC=0.
  - FETCH: address={4'h0,PC}, nRead=0; capture the instruction -> DECODE.
  - DECODE: no bus access. op==HALT_OP -> HALT. Illegal op -> NEXT. Otherwise -> RD_S1.
  - RD_S1: address={8'h10,s1}, nRead=0; capture operand A.
  - WR_S1: address=16'h2000, nWrite=0, ExeDataOut=A.
  - RD_S2: address={8'h10,s2}, nRead=0; capture operand B. Skipped when op==8'h07.
  - WR_S2: address=16'h2001, nWrite=0. ExeDataOut=B, or {248'b0,s2} when op==8'h07 (immediate in bits [15:0]).
  - EXEC: address=16'h2002, nWrite=0, ExeDataOut={248'b0,op}.
  - RD_RES: address=16'h2003, nRead=0; capture result R.
  - WR_RES: address={8'h10,dst}, nWrite=0, ExeDataOut=R.
  - NEXT: PC<=PC+1, wrapping from max to 0 -> FETCH.
  - HALT: holds until Reset. Go in HALT -> FETCH with PC=0 and IllegalOp cleared.
- nRead and nWrite are never low in the same cycle.
- In all idle cycles: address=0, both strobes high, ExeDataOut holds its last value.
- Operand registers A, B and R are 256 bits each; no arithmetic on them.

## Timing
- Reset values: address=0, nRead=1, nWrite=1, ExeDataOut=0, PC=0, Busy=0, Halted=0, IllegalOp=0, state=IDLE.
- Reset asserted mid-instruction: all outputs return to their reset values immediately (asynchronously). No partial write completes after Reset rises.
- All outputs are registered and change only on posedge Clk, so they are stable across the negedge where the matrix ALU samples them.
- Instruction latency from entering FETCH to re-entering FETCH:
  - matrix ops: 10 cycles
  - op 8'h07: 9 cycles
  - illegal op: 3 cycles
- HALT_OP reaches HALT 2 cycles after entering FETCH.
- Go while Busy or Halted is ignored, except in HALT as described under Operation.
- After Go in IDLE, the first FETCH cycle is the next cycle.

## Test plan
- Reset, then Go; imem[0]={03,30,10,20}; mem[10]=all 16'h0001, mem[20]=all 16'h0002 -> mem[30] lanes all 16'h0003. PC=1 at the next FETCH; 10 cycles FETCH-to-FETCH.
- imem[0]={07,31,10,05}, mem[10]=all 16'h0003 -> no main-memory read at 16'h1005; ALU SRC2 write data = 256'h5; mem[31] lanes all 16'h000F; 9 cycles.
- imem[0]=32'h42000000, imem[1]=FF000000 -> IllegalOp=1, no bus access with address[15:12]=2, Halted=1 with PC=1.
- Reset asserted during the EXEC cycle -> nWrite=1 and address=0 immediately; state IDLE; a following Go restarts at PC=0.
- Preload PC at max (imem at the last address holds 8'h03, imem[0] holds HALT) -> PC wraps to 0, then Halted=1.
- Throughout all runs, check nRead and nWrite are never both 0 in any cycle.

Source files
------------

// File: rtl/matrix_exe_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matrix_exe_sequencer : fetches instructions and moves operands/results
// between main memory and the matrix ALU over one shared bus.  Rev 1.0
// ---------------------------------------------------------------------------
module matrix_exe_sequencer #(
    parameter int         PC_W    = 12,
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Go,
    input  logic [255:0]    DataIn,
    output logic [15:0]     address,
    output logic            nRead,
    output logic            nWrite,
    output logic [255:0]    ExeDataOut,
    output logic [PC_W-1:0] PC,
    output logic            Busy,
    output logic            Halted,
    output logic            IllegalOp
);

    localparam logic [15:0] ALU_SRC1 = 16'h2000;
    localparam logic [15:0] ALU_SRC2 = 16'h2001;
    localparam logic [15:0] ALU_SI   = 16'h2002;
    localparam logic [15:0] ALU_RES  = 16'h2003;
    localparam logic [7:0]  OP_IMM   = 8'h07;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_RD_S1, S_WR_S1, S_RD_S2,
        S_WR_S2, S_EXEC, S_RD_RES, S_WR_RES, S_NEXT, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [255:0]    a_q, a_d, b_q, b_d, r_q, r_d;
    logic [15:0]     addr_q, addr_d;
    logic            nrd_q, nrd_d, nwr_q, nwr_d;
    logic [255:0]    dout_q, dout_d;
    logic            busy_q, busy_d, halted_q, halted_d, ill_q, ill_d;

    logic [7:0] op, dst, s1, s2;
    assign op  = instr_q[31:24];
    assign dst = instr_q[23:16];
    assign s1  = instr_q[15:8];
    assign s2  = instr_q[7:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            addr_q   <= '0;
            nrd_q    <= 1'b1;
            nwr_q    <= 1'b1;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            addr_q   <= addr_d;
            nrd_q    <= nrd_d;
            nwr_q    <= nwr_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            ill_q    <= ill_d;
        end
    end

    // Next state and data captures; reads complete on the edge leaving the state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Go) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    ill_d   = 1'b0;
                end
            end
            S_FETCH: begin
                instr_d = DataIn[31:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op == HALT_OP) begin
                    state_d = S_HALT;
                end else if (op > OP_IMM) begin
                    ill_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_RD_S1;
                end
            end
            S_RD_S1: begin
                a_d     = DataIn;
                state_d = S_WR_S1;
            end
            S_WR_S1:  state_d = (op == OP_IMM) ? S_WR_S2 : S_RD_S2;
            S_RD_S2: begin
                b_d     = DataIn;
                state_d = S_WR_S2;
            end
            S_WR_S2:  state_d = S_EXEC;
            S_EXEC:   state_d = S_RD_RES;
            S_RD_RES: begin
                r_d     = DataIn;
                state_d = S_WR_RES;
            end
            S_WR_RES: state_d = S_NEXT;
            S_NEXT: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        addr_d   = '0;
        nrd_d    = 1'b1;
        nwr_d    = 1'b1;
        dout_d   = dout_q;
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d = (state_d == S_HALT);
        case (state_d)
            S_FETCH: begin
                addr_d = {{(16-PC_W){1'b0}}, pc_d};
                nrd_d  = 1'b0;
            end
            S_RD_S1: begin
                addr_d = {8'h10, s1};
                nrd_d  = 1'b0;
            end
            S_WR_S1: begin
                addr_d = ALU_SRC1;
                nwr_d  = 1'b0;
                dout_d = a_d;
            end
            S_RD_S2: begin
                addr_d = {8'h10, s2};
                nrd_d  = 1'b0;
            end
            S_WR_S2: begin
                addr_d = ALU_SRC2;
                nwr_d  = 1'b0;
                dout_d = (op == OP_IMM) ? {248'd0, s2} : b_d;
            end
            S_EXEC: begin
                addr_d = ALU_SI;
                nwr_d  = 1'b0;
                dout_d = {248'd0, op};
            end
            S_RD_RES: begin
                addr_d = ALU_RES;
                nrd_d  = 1'b0;
            end
            S_WR_RES: begin
                addr_d = {8'h10, dst};
                nwr_d  = 1'b0;
                dout_d = r_d;
            end
            default: ;
        endcase
    end

    assign address    = addr_q;
    assign nRead      = nrd_q;
    assign nWrite     = nwr_q;
    assign ExeDataOut = dout_q;
    assign PC         = pc_q;
    assign Busy       = busy_q;
    assign Halted     = halted_q;
    assign IllegalOp  = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_exe_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_matrix_exe_sequencer : directed bench with memory and matrix ALU models.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_matrix_exe_sequencer;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Go = 1'b0;
    logic [255:0] DataIn;
    logic [15:0]  address;
    logic         nRead, nWrite;
    logic [255:0] ExeDataOut;
    logic [11:0]  PC;
    logic         Busy, Halted, IllegalOp;

    matrix_exe_sequencer #(.PC_W(12), .HALT_OP(8'hFF)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .DataIn(DataIn),
        .address(address), .nRead(nRead), .nWrite(nWrite),
        .ExeDataOut(ExeDataOut), .PC(PC), .Busy(Busy),
        .Halted(Halted), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    logic [31:0]  imem [0:4095];
    logic [255:0] mem  [0:255];
    logic [255:0] alu_src1, alu_src2, alu_res;
    int n_cmp = 0, n_err = 0;
    int cyc = 0, both_low = 0, alu_acc = 0, rd1005 = 0, fetch_bad = 0;
    int fetch_cyc[$];
    int fetch_pc[$];

    function automatic logic [255:0] lanes(input logic [15:0] v);
        return {16{v}};
    endfunction

    // Reference ALU: op 03 adds lanes, op 07 scales lanes by the immediate.
    function automatic logic [255:0] alu_fn(input logic [255:0] a, input logic [255:0] b,
                                            input logic [7:0] op);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (op == 8'h03) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
            else if (op == 8'h07) r[i*16 +: 16] = a[i*16 +: 16] * b[15:0];
        end
        return r;
    endfunction

    always_comb begin
        DataIn = '0;
        if (!nRead) begin
            case (address[15:12])
                4'h0: DataIn = {224'd0, imem[address[11:0]]};
                4'h1: DataIn = mem[address[7:0]];
                4'h2: if (address[11:0] == 12'h003) DataIn = alu_res;
                default: ;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            cyc++;
            if (!nRead && !nWrite) both_low++;
            if (!nRead && address[15:12] == 4'h0) begin
                fetch_cyc.push_back(cyc);
                fetch_pc.push_back(int'(PC));
                if (address[11:0] != PC) fetch_bad++;
            end
            if (address[15:12] == 4'h2 && (!nRead || !nWrite)) alu_acc++;
            if (!nRead && address == 16'h1005) rd1005++;
            if (!nWrite) begin
                if (address[15:8] == 8'h10) mem[address[7:0]] = ExeDataOut;
                if (address == 16'h2000) alu_src1 = ExeDataOut;
                if (address == 16'h2001) alu_src2 = ExeDataOut;
                if (address == 16'h2002) alu_res = alu_fn(alu_src1, alu_src2, ExeDataOut[7:0]);
            end
        end
    end

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        fetch_cyc.delete();
        fetch_pc.delete();
        alu_acc = 0;
        rd1005  = 0;
    endtask

    task automatic go_pulse();
        @(negedge Clk);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
    endtask

    task automatic wait_halted(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (Halted) break;
        end
        #1;
        check(name, Halted, 1'b1);
    endtask

    initial begin
        int n;
        logic found;
        for (int i = 0; i < 4096; i++) imem[i] = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        alu_src1 = '0; alu_src2 = '0; alu_res = '0;

        // Test 1: lane add
        imem[0] = 32'h03301020; imem[1] = 32'hFF000000;
        mem[8'h10] = lanes(16'h0001); mem[8'h20] = lanes(16'h0002);
        apply_reset();
        #1;
        check("rst_address", address, 16'h0);
        check("rst_nRead", nRead, 1'b1);
        check("rst_nWrite", nWrite, 1'b1);
        check("rst_dout", ExeDataOut, 256'h0);
        check("rst_pc", PC, 12'h0);
        check("rst_busy", Busy, 1'b0);
        check("rst_halted", Halted, 1'b0);
        check("rst_illegal", IllegalOp, 1'b0);
        go_pulse();
        #1;
        check("t1_first_fetch", {Busy, nRead, address}, {1'b1, 1'b0, 16'h0000});
        wait_halted(100, "t1_halt");
        check("t1_result", mem[8'h30], lanes(16'h0003));
        check("t1_nfetch", fetch_pc.size(), 2);
        check("t1_pc_next", fetch_pc[1], 1);
        check("t1_latency", fetch_cyc[1] - fetch_cyc[0], 10);
        check("t1_pc_halt", PC, 12'h1);
        check("t1_busy", Busy, 1'b0);
        check("t1_illegal", IllegalOp, 1'b0);

        // Test 2: immediate scale
        imem[0] = 32'h07311005; imem[1] = 32'hFF000000;
        mem[8'h10] = lanes(16'h0003); mem[8'h05] = lanes(16'hDEAD);
        apply_reset();
        go_pulse();
        wait_halted(100, "t2_halt");
        check("t2_no_rd1005", rd1005, 0);
        check("t2_src2_imm", alu_src2, 256'h5);
        check("t2_result", mem[8'h31], lanes(16'h000F));
        check("t2_latency", fetch_cyc[1] - fetch_cyc[0], 9);

        // Test 3: illegal opcode, halt, restart from HALT
        imem[0] = 32'h42000000; imem[1] = 32'hFF000000;
        apply_reset();
        go_pulse();
        wait_halted(100, "t3_halt");
        check("t3_illegal", IllegalOp, 1'b1);
        check("t3_no_alu", alu_acc, 0);
        check("t3_pc", PC, 12'h1);
        check("t3_latency", fetch_cyc[1] - fetch_cyc[0], 3);
        repeat (5) @(negedge Clk);
        #1;
        check("t3_hold", {Halted, Busy, nRead, nWrite, address}, {1'b1, 1'b0, 1'b1, 1'b1, 16'h0});
        go_pulse();
        #1;
        check("t3_restart", {Busy, Halted, IllegalOp, nRead}, {1'b1, 1'b0, 1'b0, 1'b0});
        check("t3_restart_pc", {PC, address}, {12'h0, 16'h0});
        wait_halted(100, "t3_halt2");

        // Test 4: asynchronous reset in EXEC
        imem[0] = 32'h03301020; imem[1] = 32'hFF000000;
        mem[8'h10] = lanes(16'h0001); mem[8'h20] = lanes(16'h0002); mem[8'h30] = '0;
        apply_reset();
        go_pulse();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            #1;
            if (address == 16'h2002 && !nWrite) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_exec_seen", found, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("t4_async", {nWrite, nRead, Busy, address}, {1'b1, 1'b1, 1'b0, 16'h0});
        check("t4_async_dout", {PC, ExeDataOut}, {12'h0, 256'h0});
        @(negedge Clk);
        Reset = 1'b0;
        fetch_cyc.delete();
        fetch_pc.delete();
        repeat (3) @(negedge Clk);
        #1;
        check("t4_no_write", mem[8'h30], 256'h0);
        check("t4_idle", {Busy, Halted, nRead, nWrite}, {1'b0, 1'b0, 1'b1, 1'b1});
        go_pulse();
        #1;
        check("t4_restart", {PC, address, nRead}, {12'h0, 16'h0, 1'b0});
        wait_halted(100, "t4_halt");
        check("t4_result", mem[8'h30], lanes(16'h0003));

        // Test 5: PC wrap from 4095 to 0
        for (int i = 0; i < 4095; i++) imem[i] = 32'h42000000;
        imem[4095] = 32'h03321020;
        mem[8'h32] = '0;
        apply_reset();
        go_pulse();
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (PC != 12'h0) break;
        end
        imem[0] = 32'hFF000000;
        wait_halted(20000, "t5_halt");
        n = fetch_pc.size();
        check("t5_pc", PC, 12'h0);
        check("t5_result", mem[8'h32], lanes(16'h0003));
        check("t5_illegal", IllegalOp, 1'b1);
        check("t5_pc_max", fetch_pc[n-2], 4095);
        check("t5_pc_wrap", fetch_pc[n-1], 0);
        check("t5_latency", fetch_cyc[n-1] - fetch_cyc[n-2], 10);

        check("fetch_addr_pc", fetch_bad, 0);
        check("strobes_exclusive", both_low, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
